// File: rtl/arm_hps_system_debounced_pio.sv
// Avalon-MM input PIO with 2-flop synchroniser, per-bit debounce filter,
// selectable rising/falling edge capture and a maskable level interrupt.
module arm_hps_system_debounced_pio #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    // A limit of 0 or 1 both mean "accept a new level after a single mismatching cycle".
    localparam int unsigned      DB_LIMIT = (DEBOUNCE_CYCLES > 1) ? DEBOUNCE_CYCLES : 1;
    localparam int unsigned      CNT_W    = (DB_LIMIT > 1) ? $clog2(DB_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_LIMIT - 1);

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_RISE_EN = 3'd1;
    localparam logic [2:0] ADDR_MASK    = 3'd2;
    localparam logic [2:0] ADDR_CAPTURE = 3'd3;
    localparam logic [2:0] ADDR_FALL_EN = 3'd4;
    localparam logic [2:0] ADDR_RAW     = 3'd5;

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_stable;
    logic [WIDTH-1:0] r_stable_d;
    logic [CNT_W-1:0] r_cnt [WIDTH];
    logic [WIDTH-1:0] r_rise_en;
    logic [WIDTH-1:0] r_fall_en;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_capture;

    logic             w_wr;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_clr;
    logic [31:0]      w_rdata;
    logic             w_unused_wdata;

    assign w_wr           = chipselect & ~write_n;
    assign w_wdata        = writedata[WIDTH-1:0];
    assign w_unused_wdata = ^writedata;

    assign w_rise = r_stable & ~r_stable_d & r_rise_en;
    assign w_fall = ~r_stable & r_stable_d & r_fall_en;
    assign w_clr  = (w_wr && address == ADDR_CAPTURE) ? w_wdata : '0;

    assign irq = |(r_capture & r_mask);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= in_port;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stable   <= '0;
            r_stable_d <= '0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_stable_d <= r_stable;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_LAST) begin
                    r_stable[i] <= r_sync2[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rise_en <= '0;
            r_fall_en <= '1;
            r_mask    <= '0;
        end else if (w_wr) begin
            case (address)
                ADDR_RISE_EN: r_rise_en <= w_wdata;
                ADDR_MASK:    r_mask    <= w_wdata;
                ADDR_FALL_EN: r_fall_en <= w_wdata;
                default: ;
            endcase
        end
    end

    // Set is OR-ed in after the clear so a coincident edge is never lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_capture <= '0;
        end else begin
            r_capture <= (r_capture & ~w_clr) | w_rise | w_fall;
        end
    end

    always_comb begin
        w_rdata = '0;
        case (address)
            ADDR_DATA:    w_rdata[WIDTH-1:0] = r_stable;
            ADDR_RISE_EN: w_rdata[WIDTH-1:0] = r_rise_en;
            ADDR_MASK:    w_rdata[WIDTH-1:0] = r_mask;
            ADDR_CAPTURE: w_rdata[WIDTH-1:0] = r_capture;
            ADDR_FALL_EN: w_rdata[WIDTH-1:0] = r_fall_en;
            ADDR_RAW:     w_rdata[WIDTH-1:0] = r_sync2;
            default:      w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= w_rdata;
        end
    end

endmodule

// File: doc/arm_hps_system_debounced_pio.md
# arm_hps_system_debounced_pio

Parametrised Avalon-MM input PIO for push buttons and switches on the HPS lightweight bridge; successor to the fixed 4-bit edge-capture PIO. Adds configurable width, a 2-flop synchroniser, per-bit debounce filtering, and software-selectable rising/falling edge capture. It also provides a maskable level interrupt to the HPS GIC.

## Interface
- WIDTH, 4, number of input bits (1..32)
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required before a level is accepted (0 or 1 = no filtering); counter width = clog2(DEBOUNCE_CYCLES+1)
- clk  in  1  system clock; single clock domain
- reset_n  in  1  asynchronous, active-low reset
- address  in  3  register word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data; bits above WIDTH ignored
- in_port  in  WIDTH  raw asynchronous inputs
- readdata  out  32  registered read data; bits above WIDTH read 0
- irq  out  1  level interrupt

## Operation
- Register map:
  - 0 DATA: RO, debounced levels
  - 1 RISE_EN: RW
  - 2 IRQ_MASK: RW
  - 3 EDGE_CAPTURE: write-1-to-clear
  - 4 FALL_EN: RW
  - 5 RAW: RO, synchronised, unfiltered
  - 6–7: read 0, writes ignored
- Writes take effect when chipselect=1 and write_n=0; no wait states. Writes to RO addresses are ignored.
- Reset values:
  - sync flops, stable, counters, readdata, IRQ_MASK, EDGE_CAPTURE, RISE_EN: 0
  - FALL_EN: all ones, so buttons are active-low and a press is a falling edge
  - irq: 0
- Synchroniser: sync1 <= in_port; sync2 <= sync1.
- Debounce, per bit i, with cnt[i] and stable[i]:
  - sync2[i]==stable[i]: cnt[i] <= 0.
  - Mismatch and cnt[i]==max(DEBOUNCE_CYCLES,1)-1: stable[i] <= sync2[i]; cnt[i] <= 0.
  - Otherwise: cnt[i] <= cnt[i]+1.
  - Any glitch that returns to the stable level restarts the count.
- Edge detect: stable_d is stable delayed by one cycle.
  - rise = stable & ~stable_d & RISE_EN
  - fall = ~stable & stable_d & FALL_EN
- EDGE_CAPTURE[i]:
  - Sets on rise[i]|fall[i].
  - Clears on a write to address 3 with writedata[i]=1.
  - A set and a clear in the same cycle: set wins (no lost events).
  - Clearing a bit does not affect other bits.
- Changing RISE_EN/FALL_EN never alters existing capture bits. It does not create edges; only subsequent stable transitions are qualified.
- irq = |(EDGE_CAPTURE & IRQ_MASK), combinational from registers. Masking a pending bit deasserts irq without clearing the capture.
- Reads:
  - readdata <= zero-extended mux(address) on every clock, independent of chipselect.
  - Reads have no side effects.

## Timing
- Read latency is 1 cycle: readdata is valid on the edge after address is presented.
- A read and write to the same register in the same cycle return the pre-write value.
- in_port changes before edge t0:
  - sync2 reflects the new value after t1; RAW is readable from t2.
  - stable updates at edge t1+max(DEBOUNCE_CYCLES,1).
  - EDGE_CAPTURE sets one edge later, at t2+max(DEBOUNCE_CYCLES,1); irq is high after that edge when masked in.
- Register writes are visible after the write edge; irq follows IRQ_MASK or a capture clear in the same cycle.
- Asynchronous reset mid-debounce:
  - All counters and state clear immediately and irq drops.
  - After release, stable=0. An input held high is then accepted as a rising transition after the full debounce delay.
- Counter never exceeds DEBOUNCE_CYCLES-1; no wrap-around.

## Test plan
- Reset, then read addresses 0–7 with in_port=0 → DATA 0, RISE_EN 0, IRQ_MASK 0, CAPTURE 0, FALL_EN 0xF, RAW 0, 6/7 = 0; irq=0.
- DEBOUNCE_CYCLES=4, WIDTH=4:
  - Stimulus: in_port 0xF→0xE held at t0.
  - Response: DATA reads 0xE after edge t5; EDGE_CAPTURE=0x1 after t6; irq=1 only once IRQ_MASK=0x1 is written.
- Glitch rejection with DEBOUNCE_CYCLES=4:
  - Stimulus: bit 0 low for 3 cycles, then back high.
  - Response: DATA stays 0xF; CAPTURE stays 0; cnt returns to 0.
- Rising-edge mode:
  - Stimulus: write RISE_EN=0x2, FALL_EN=0; toggle bit 1 0→1→0 with full debounce.
  - Response: CAPTURE=0x2 after the rise only. Write 0x2 to address 3 → CAPTURE=0, irq=0.
- Same-cycle clear and set:
  - Stimulus: write 0x1 to address 3 on the cycle a new bit-0 edge is detected.
  - Response: CAPTURE[0] remains 1.
- Assert reset_n=0 mid-count with IRQ pending → irq and readdata 0 immediately; WIDTH=32, DEBOUNCE_CYCLES=0 build: bit 31 toggle captured at t3.
